// File: rtl/regfile_dbg_pkg.sv
// Shared types and default sizing for the register-file debug dump engine.
package regfile_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  localparam int REG_COUNT = 32;
  localparam int REG_W     = 64;
  localparam int REG_AW    = 5;
  localparam int XZR_IDX   = 31;

endpackage

// File: rtl/regfile_dump.sv
// Walks one regfile read port from X0 to X(N_REGS-1) and streams each value
// out as an (address, data) beat over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for start; ra parked at 0
//   READ  | ra = idx, rd captured into out_data on the next edge
//   SEND  | beat presented, held until out_ready is sampled high
//   DONE  | one-cycle done pulse, then back to IDLE
module regfile_dump
  import regfile_dbg_pkg::*;
#(
  parameter int N_REGS = REG_COUNT,
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_REGS - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ra_d        = ra_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        ra_d        = '0;
        out_valid_d = 1'b0;
        if (start) begin
          idx_d   = '0;
          ra_d    = '0;
          busy_d  = 1'b1;
          state_d = READ;
        end
      end

      // rd is combinational from ra, so the value seen here is the pre-edge
      // contents: a write landing on this same edge is not reflected.
      READ: begin
        out_data_d  = rd;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end

      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            ra_d    = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            ra_d    = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        idx_d       = '0;
        ra_d        = '0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ra_q        <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ra_q        <= ra_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ra        = ra_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a behavioural regfile plus a
// snapshot-based reference of the beat stream each dump must produce.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  ra;
  logic [63:0] rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [63:0] out_data;
  logic        busy;
  logic        done;

  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [63:0] rf [32];
  logic [63:0] ref_mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_dump dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ra        (ra),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  // Single-cycle-processor regfile: write on the rising edge, XZR reads 0.
  always_ff @(posedge clk) begin
    if (we3 && wa3 != 5'd31) rf[wa3] <= wd3;
  end
  assign rd = (ra == 5'd31) ? 64'd0 : rf[ra];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < 31; i++) begin
      we3 = 1'b1;
      wa3 = 5'(i);
      wd3 = rnd ? {$urandom, $urandom} : 64'h100 + 64'(i);
      ref_mem[i] = wd3;
      tick();
    end
    we3 = 1'b0;
    ref_mem[31] = 64'd0;
  endtask

  // mode: 0 ready always high, 1 ready 1-of-3, 2 random ready.
  task automatic do_dump(input int mode, input int write_edge, input int abort_edge,
                         input bit hold, input int pulse_a, input int pulse_b,
                         input int exp_done_edge);
    logic [63:0] exp_q [32];
    int          n, beats;
    bit          finished, aborted, saw_bad;
    logic        v, r;
    logic [4:0]  a;
    logic [63:0] d;

    for (int i = 0; i < 32; i++) exp_q[i] = (i == 31) ? 64'd0 : ref_mem[i];
    n = 0; beats = 0; finished = 0; aborted = 0;

    start = 1'b1;
    out_ready = 1'b0;
    tick();
    start = hold;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("valid_after_start", 64'(out_valid), 64'd0);

    while (!finished && !aborted && n < 1500) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((n % 3) == 2);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      start = hold || (n + 1 == pulse_a) || (n + 1 == pulse_b);
      if (n + 1 == write_edge) begin
        we3 = 1'b1;
        wa3 = 5'd5;
        wd3 = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      v = out_valid; r = out_ready; a = out_addr; d = out_data;
      if (v) chk("ra_matches_beat", 64'(ra), 64'(a));
      tick();
      n++;
      if (we3) begin
        we3 = 1'b0;
        ref_mem[5] = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      if (v && r) begin
        chk("beat_addr", 64'(a), 64'(beats));
        chk("beat_data", d, exp_q[beats]);
        beats++;
      end else if (v) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_addr", 64'(out_addr), 64'(a));
        chk("stall_data", out_data, d);
      end
      if (n == abort_edge) begin
        chk("abort_in_send", 64'(out_valid), 64'd1);
        chk("abort_beat_idx", 64'(out_addr), 64'(beats));
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_addr", 64'(out_addr), 64'd0);
        chk("abort_data", out_data, 64'd0);
        chk("abort_ra", 64'(ra), 64'd0);
        saw_bad = 0;
        for (int i = 0; i < 70; i++) begin
          tick();
          if (done || busy || out_valid) saw_bad = 1;
        end
        chk("abort_stays_idle", 64'(saw_bad), 64'd0);
        aborted = 1;
      end else if (done) begin
        chk("done_beat_count", 64'(beats), 64'd32);
        if (exp_done_edge > 0) chk("done_edge", 64'(n), 64'(exp_done_edge));
        chk("done_busy", 64'(busy), 64'd1);
        finished = 1;
      end
    end

    if (!aborted) begin
      if (!finished) chk("dump_timeout", 64'd0, 64'd1);
      out_ready = 1'b0;
      tick();
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_ra", 64'(ra), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    we3 = 1'b0; wa3 = '0; wd3 = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ra", 64'(ra), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_data", out_data, 64'd0);
    reset = 1'b0;
    tick();

    preload(1'b0);
    do_dump(0, -1, -1, 1'b0, -1, -1, 64);
    do_dump(1, -1, -1, 1'b0, -1, -1, -1);

    // X5 written on beat 5's capture edge (E11), then a repeat dump.
    do_dump(0, 11, -1, 1'b0, -1, -1, 64);
    do_dump(0, -1, -1, 1'b0, -1, -1, 64);

    // Reset while beat 10 is presented, then a fresh dump from X0.
    do_dump(0, -1, 21, 1'b0, -1, -1, -1);
    do_dump(0, -1, -1, 1'b0, -1, -1, 64);

    // start pulses while beats 3 and 20 are presented must be ignored.
    do_dump(0, -1, -1, 1'b0, 8, 42, 64);
    tick();
    chk("no_queued_restart", 64'(busy), 64'd0);

    // start held high: back-to-back dumps with one IDLE cycle between.
    do_dump(0, -1, -1, 1'b1, -1, -1, 64);
    do_dump(0, -1, -1, 1'b1, -1, -1, 64);
    start = 1'b0;
    tick();
    chk("hold_release_idle", 64'(busy), 64'd0);

    preload(1'b1);
    do_dump(2, -1, -1, 1'b0, -1, -1, -1);
    preload(1'b1);
    do_dump(2, -1, -1, 1'b0, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the single-cycle processor's 32 x 64-bit register file. On a `start` pulse it walks one regfile read port from X0 to X31. It captures each value and streams it out as (address, data) beats over a valid/ready handshake, so a bench or debug host can snapshot architectural state without stopping the datapath. It is the reading master on the regfile's `ra`/`rd` port pair.

## Interface
- `N_REGS`, 32, number of registers walked, X0..X(N_REGS-1)
- `DATA_W`, 64, register width
- `ADDR_W`, 5, register address width; must satisfy 2**ADDR_W >= N_REGS
- `clk`  in  1  rising-edge clock, shared with regfile
- `reset`  in  1  synchronous, active-high reset; sampled on `clk` rising edge
- `start`  in  1  begin a dump; sampled only in IDLE
- `ra`  out  ADDR_W  regfile read address (to `ra1` or `ra2`)
- `rd`  in  DATA_W  regfile read data, combinational from `ra`
- `out_valid`  out  1  beat available
- `out_ready`  in  1  consumer accepts beat
- `out_addr`  out  ADDR_W  register index of current beat
- `out_data`  out  DATA_W  captured register value
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse after last beat accepted

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: `ra`=0, `out_valid`=0. If `start`=1, then `idx`<=0 and go to READ. Otherwise stay in IDLE.
- READ: drive `ra`=`idx`. At the next edge, `out_data`<=`rd`, `out_addr`<=`idx`, `out_valid`<=1, and go to SEND.
- SEND: hold `out_valid`, `out_addr`, `out_data` and `ra` stable until `out_ready`=1 is sampled.
  - On handshake with `idx`==N_REGS-1: `out_valid`<=0, go to DONE.
  - On handshake otherwise: `idx`<=`idx`+1, `out_valid`<=0, go to READ.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. No queuing, no restart.
- X31 (XZR) is dumped like any other index; its value is whatever the regfile returns (0).
- Capture semantics: the regfile writes on the same rising edge.
  - A write to register `idx` on the capture edge is not reflected; the old value is captured.
  - A write on any earlier edge is reflected.
- `idx` is ADDR_W bits. The walk stops at N_REGS-1 and never wraps past it.

## Timing
- Reset values: state IDLE; `ra`, `out_addr`, `out_data`, `idx` all 0; `out_valid`, `busy`, `done` all 0.
- Reset asserted mid-dump: the next edge forces all reset values. No `done` is issued and the partial dump is abandoned.
- Edge E0 samples `start` in IDLE. `busy`=1 from E0+.
- First beat `out_valid`=1 after E1.
- With `out_ready` tied high, each beat takes 2 cycles:
  - Beat k is valid in the cycle after edge E(2k+1).
  - The last handshake is at E64.
  - `done` is high in the cycle after E64.
  - `busy` falls after E65.
- Total: 66 cycles from `start` sampled to IDLE with back-pressure-free consumer.
- `out_valid` never drops without a handshake. `out_data`/`out_addr` never change while `out_valid`=1 and `out_ready`=0.
- `start` held high continuously: a new dump begins on the first IDLE cycle after DONE.

## Structure
- Shared package `regfile_dbg_pkg`:
  - `dump_state_t` enum (IDLE, READ, SEND, DONE).
  - Default constants `REG_COUNT`=32, `REG_W`=64, `REG_AW`=5, `XZR_IDX`=31.
- Single flat module: one FSM plus index counter and output registers. No sub-module is warranted.

## Test plan
- Reset, then preload X0..X30 with 64'h100+i via regfile port 3; `start`=1 for one cycle, `out_ready`=1 -> 32 beats, `out_addr`=0..31 in order, `out_data`=64'h100+i, X31 beat data 0, `done` pulse at cycle 65 after start edge.
- Same dump with `out_ready` toggled 1-of-3 cycles -> identical beat sequence. Every stalled beat holds addr/data stable. No beat is lost or duplicated.
- Write X5=64'hFFFF_FFFF_FFFF_FFFF on the capture edge of beat 5 -> beat 5 carries the old value. A repeat dump carries all-ones.
- Assert `reset` while in SEND at beat 10 -> next cycle `out_valid`=0, `busy`=0, no `done`. A fresh `start` restarts at `out_addr`=0.
- Pulse `start` during beats 3 and 20 -> ignored; exactly one 32-beat dump and one `done`.
- Hold `start`=1 continuously -> back-to-back dumps. IDLE lasts one cycle between them, and `done` pulses once per dump.
